// File: rtl/gpu_irq_req.sv
// GPU IRQ request sequencer. GP0 0x1F queues an IRQ request. Each queued request raises
// o_setIRQ only after the draw pipeline has been idle long enough. GP1 acks and resets are handled here too.
module gpu_irq_req #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_nRst,
  input  logic       i_gp0Valid,
  input  logic [7:0] i_gp0Opcode,
  output logic       o_gp0Ready,
  input  logic       i_gp1Valid,
  input  logic [7:0] i_gp1Opcode,
  input  logic       i_drawBusy,
  output logic       o_setIRQ,
  output logic       o_rstIRQ,
  output logic [1:0] o_pendCnt,
  output logic       o_irqBusy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_IDLE = 2'd1,
    FIRE      = 2'd2
  } state_e;

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  state_e     state_q, state_d;
  logic [1:0] pend_q, pend_d;
  logic [3:0] settle_q, settle_d;
  logic       rst_irq_q, rst_irq_d;

  logic gp0_inc;
  logic gp1_clr;
  logic fire_go;

  assign o_gp0Ready = (pend_q != 2'd3);
  assign gp0_inc    = i_gp0Valid && o_gp0Ready && (i_gp0Opcode == 8'h1F);
  assign gp1_clr    = i_gp1Valid && ((i_gp1Opcode == 8'h00) || (i_gp1Opcode == 8'h01));
  assign rst_irq_d  = i_gp1Valid && ((i_gp1Opcode == 8'h00) || (i_gp1Opcode == 8'h02));
  // A pending acknowledge pulse blocks the FIRE pulse, so set and reset never overlap.
  assign fire_go    = (state_q == FIRE) && !rst_irq_q;

  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      settle_q  <= '0;
      rst_irq_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      settle_q  <= settle_d;
      rst_irq_q <= rst_irq_d;
    end
  end

  always_comb begin
    pend_d = pend_q;
    if (gp1_clr) begin
      pend_d = '0;
    end else if (gp0_inc && !fire_go) begin
      pend_d = pend_q + 2'd1;
    end else if (!gp0_inc && fire_go && (pend_q != 2'd0)) begin
      pend_d = pend_q - 2'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    if (gp1_clr) begin
      state_d  = IDLE;
      settle_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pend_q != 2'd0) begin
            state_d  = WAIT_IDLE;
            settle_d = '0;
          end
        end
        WAIT_IDLE: begin
          if (settle_q >= SETTLE) begin
            state_d  = FIRE;
            settle_d = '0;
          end else if (i_drawBusy) begin
            settle_d = '0;
          end else begin
            settle_d = settle_q + 4'd1;
          end
        end
        FIRE: begin
          if (fire_go) begin
            settle_d = '0;
            state_d  = (pend_d != 2'd0) ? WAIT_IDLE : IDLE;
          end
        end
        default: begin
          state_d  = IDLE;
          settle_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    o_setIRQ  = fire_go;
    o_rstIRQ  = rst_irq_q;
    o_pendCnt = pend_q;
    o_irqBusy = (state_q != IDLE);
  end

endmodule

// File: tb/tb_gpu_irq_req.sv
// Bench for gpu_irq_req: a request-queue model checked on every falling edge, plus
// directed scenarios with hand-computed cycle expectations.
module tb_gpu_irq_req;

  localparam int unsigned SETTLE = 2;

  logic       i_clk;
  logic       i_nRst;
  logic       i_gp0Valid;
  logic [7:0] i_gp0Opcode;
  logic       o_gp0Ready;
  logic       i_gp1Valid;
  logic [7:0] i_gp1Opcode;
  logic       i_drawBusy;
  logic       o_setIRQ;
  logic       o_rstIRQ;
  logic [1:0] o_pendCnt;
  logic       o_irqBusy;

  int errors = 0;
  int checks = 0;
  int ncyc   = 0;
  int set_cyc[$];

  gpu_irq_req #(.SETTLE_CYCLES(SETTLE)) dut (
    .i_clk      (i_clk),
    .i_nRst     (i_nRst),
    .i_gp0Valid (i_gp0Valid),
    .i_gp0Opcode(i_gp0Opcode),
    .o_gp0Ready (o_gp0Ready),
    .i_gp1Valid (i_gp1Valid),
    .i_gp1Opcode(i_gp1Opcode),
    .i_drawBusy (i_drawBusy),
    .o_setIRQ   (o_setIRQ),
    .o_rstIRQ   (o_rstIRQ),
    .o_pendCnt  (o_pendCnt),
    .o_irqBusy  (o_irqBusy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a queue of requests; an armed request waits for SETTLE quiet cycles, then fires
  // unless an acknowledge pulse is occupying the IRQ line.
  int m_pend, m_quiet;
  bit m_armed, m_firing, m_ack;

  always @(negedge i_clk) begin
    bit fire_now, acc, clr, ack_next;
    int np;
    if (!i_nRst) begin
      m_pend = 0; m_quiet = 0; m_armed = 0; m_firing = 0; m_ack = 0;
    end
    fire_now = m_firing && !m_ack;
    chk("setIRQ",   int'(o_setIRQ),  int'(fire_now));
    chk("rstIRQ",   int'(o_rstIRQ),  int'(m_ack));
    chk("pendCnt",  int'(o_pendCnt), m_pend);
    chk("irqBusy",  int'(o_irqBusy), int'(m_armed || m_firing));
    chk("gp0Ready", int'(o_gp0Ready), int'(m_pend != 3));
    chk("exclusive", int'(o_setIRQ && o_rstIRQ), 0);
    if (o_setIRQ) set_cyc.push_back(ncyc);
    ncyc++;
    if (i_nRst) begin
      acc      = i_gp0Valid && (m_pend != 3) && (i_gp0Opcode == 8'h1F);
      clr      = i_gp1Valid && (i_gp1Opcode inside {8'h00, 8'h01});
      ack_next = i_gp1Valid && (i_gp1Opcode inside {8'h00, 8'h02});
      if (clr) begin
        m_pend = 0; m_quiet = 0; m_armed = 0; m_firing = 0;
      end else begin
        np = m_pend + int'(acc) - int'(fire_now);
        if (m_firing) begin
          if (fire_now) begin
            m_firing = 0;
            m_armed  = (np != 0);
            m_quiet  = 0;
          end
        end else if (m_armed) begin
          if (m_quiet >= SETTLE) begin
            m_firing = 1; m_armed = 0; m_quiet = 0;
          end else begin
            m_quiet = i_drawBusy ? 0 : m_quiet + 1;
          end
        end else if (m_pend != 0) begin
          m_armed = 1; m_quiet = 0;
        end
        m_pend = np;
      end
      m_ack = ack_next;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clr_in();
    i_gp0Valid  = 1'b0;
    i_gp0Opcode = 8'h00;
    i_gp1Valid  = 1'b0;
    i_gp1Opcode = 8'h00;
  endtask

  initial begin
    int n0;
    i_nRst = 1'b0;
    i_drawBusy = 1'b0;
    clr_in();
    repeat (3) tick();
    chk("reset_ready", int'(o_gp0Ready), 1);
    chk("reset_pend",  int'(o_pendCnt), 0);
    i_nRst = 1'b1;
    repeat (2) tick();

    // Single IRQ, idle pipeline: pulse on cycle 5
    n0 = set_cyc.size();
    for (int k = 0; k < 8; k++) begin
      tick();
      clr_in();
      if (k == 0) begin i_gp0Valid = 1'b1; i_gp0Opcode = 8'h1F; end
      chk("single_set", int'(o_setIRQ), int'(k == 5));
      if (k == 1) chk("single_pend1", int'(o_pendCnt), 1);
      if (k == 2) chk("single_busy2", int'(o_irqBusy), 1);
      if (k == 7) chk("single_pend0", int'(o_pendCnt), 0);
    end
    chk("single_count", set_cyc.size() - n0, 1);

    // Non-IRQ GP0 opcode and unknown GP1 opcode have no effect
    tick(); i_gp0Valid = 1'b1; i_gp0Opcode = 8'h02; i_gp1Valid = 1'b1; i_gp1Opcode = 8'h05;
    tick(); clr_in();
    chk("other_pend", int'(o_pendCnt), 0);
    chk("other_rst",  int'(o_rstIRQ), 0);
    repeat (3) tick();

    // Busy gating with a one-cycle low glitch at cycle 5: pulse on cycle 13
    n0 = set_cyc.size();
    for (int k = 0; k < 16; k++) begin
      tick();
      clr_in();
      if (k == 0) begin i_gp0Valid = 1'b1; i_gp0Opcode = 8'h1F; end
      i_drawBusy = (k < 10) && (k != 5);
      chk("gate_set", int'(o_setIRQ), int'(k == 13));
    end
    chk("gate_count", set_cyc.size() - n0, 1);

    // Full queue: fourth request refused; three pulses at 7, 11, 15
    n0 = set_cyc.size();
    for (int k = 0; k < 20; k++) begin
      tick();
      clr_in();
      if (k < 4) begin i_gp0Valid = 1'b1; i_gp0Opcode = 8'h1F; end
      i_drawBusy = (k < 4);
      if (k == 3) chk("full_ready", int'(o_gp0Ready), 0);
      if (k == 4) chk("full_pend3", int'(o_pendCnt), 3);
      chk("full_set", int'(o_setIRQ), int'(k == 7 || k == 11 || k == 15));
    end
    chk("full_count", set_cyc.size() - n0, 3);
    if (set_cyc.size() - n0 == 3) begin
      chk("full_gap1", int'(set_cyc[n0+1] - set_cyc[n0] >= SETTLE + 1), 1);
      chk("full_gap2", int'(set_cyc[n0+2] - set_cyc[n0+1] >= SETTLE + 1), 1);
    end

    // Ack collision: ack on cycle 4 puts rstIRQ on cycle 5, set moves to cycle 6
    for (int k = 0; k < 9; k++) begin
      tick();
      clr_in();
      if (k == 0) begin i_gp0Valid = 1'b1; i_gp0Opcode = 8'h1F; end
      if (k == 4) begin i_gp1Valid = 1'b1; i_gp1Opcode = 8'h02; end
      chk("ack_rst", int'(o_rstIRQ), int'(k == 5));
      chk("ack_set", int'(o_setIRQ), int'(k == 6));
    end

    // Same-edge increment and fire: count stays 1, second pulse 4 cycles later
    for (int k = 0; k < 12; k++) begin
      tick();
      clr_in();
      if (k == 0 || k == 5) begin i_gp0Valid = 1'b1; i_gp0Opcode = 8'h1F; end
      if (k == 6) chk("coinc_pend", int'(o_pendCnt), 1);
      chk("coinc_set", int'(o_setIRQ), int'(k == 5 || k == 9));
    end

    // Buffer reset with same-cycle 0x1F while two requests wait
    n0 = set_cyc.size();
    for (int k = 0; k < 14; k++) begin
      tick();
      clr_in();
      i_drawBusy = (k < 6);
      if (k < 2) begin i_gp0Valid = 1'b1; i_gp0Opcode = 8'h1F; end
      if (k == 3) begin
        chk("bufrst_pre", int'(o_pendCnt), 2);
        i_gp0Valid = 1'b1; i_gp0Opcode = 8'h1F;
        i_gp1Valid = 1'b1; i_gp1Opcode = 8'h01;
      end
      if (k == 4) begin
        chk("bufrst_pend", int'(o_pendCnt), 0);
        chk("bufrst_idle", int'(o_irqBusy), 0);
      end
      chk("bufrst_rst", int'(o_rstIRQ), 0);
    end
    chk("bufrst_noset", set_cyc.size() - n0, 0);

    // GPU reset: clears queue and pulses rstIRQ next cycle
    for (int k = 0; k < 5; k++) begin
      tick();
      clr_in();
      i_drawBusy = 1'b1;
      if (k == 0) begin i_gp0Valid = 1'b1; i_gp0Opcode = 8'h1F; end
      if (k == 2) begin i_gp1Valid = 1'b1; i_gp1Opcode = 8'h00; end
      chk("gpurst_rst", int'(o_rstIRQ), int'(k == 3));
      if (k == 3) chk("gpurst_pend", int'(o_pendCnt), 0);
    end

    // Async reset mid-WAIT_IDLE, between clock edges
    tick(); i_drawBusy = 1'b1; i_gp0Valid = 1'b1; i_gp0Opcode = 8'h1F;
    tick(); clr_in();
    tick();
    tick();
    chk("async_prebusy", int'(o_irqBusy), 1);
    #2 i_nRst = 1'b0;
    #1;
    chk("async_pend",  int'(o_pendCnt), 0);
    chk("async_busy",  int'(o_irqBusy), 0);
    chk("async_set",   int'(o_setIRQ), 0);
    chk("async_rst",   int'(o_rstIRQ), 0);
    chk("async_ready", int'(o_gp0Ready), 1);
    tick();
    i_nRst = 1'b1;
    i_drawBusy = 1'b0;
    n0 = set_cyc.size();
    repeat (10) tick();
    chk("async_dropped", set_cyc.size() - n0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpu_irq_req.md
GPU_IRQ_REQ -- requirements
Module: gpu_irq_req

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: number of consecutive cycles i_drawBusy must be low before a queued IRQ request fires (legal range 1..15).
REQ-002 SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_nRst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_gp0Valid  input  1  decoded GP0 command opcode valid.
REQ-005 SHALL have port i_gp0Opcode  input  8  decoded GP0 command opcode (bits 31:24 of the command word).
REQ-006 SHALL have port o_gp0Ready  output  1  block can accept a GP0 opcode this cycle.
REQ-007 SHALL have port i_gp1Valid  input  1  GP1 write strobe, one cycle per write.
REQ-008 SHALL have port i_gp1Opcode  input  8  GP1 command opcode.
REQ-009 SHALL have port i_drawBusy  input  1  draw pipeline busy with previously issued GP0 commands.
REQ-010 SHALL have port o_setIRQ  output  1  one-cycle pulse, drives the IRQ latch set input.
REQ-011 SHALL have port o_rstIRQ  output  1  one-cycle pulse, drives the IRQ latch reset input.
REQ-012 SHALL have port o_pendCnt  output  2  number of queued, not yet fired IRQ requests (0..3).
REQ-013 SHALL have port o_irqBusy  output  1  high whenever FSM is not IDLE.

Function
REQ-014 SHALL define a GP0 handshake as accepted on a cycle where i_gp0Valid and o_gp0Ready are both high.
REQ-015 SHALL drive o_gp0Ready combinationally low when o_pendCnt equals 3, high otherwise.
REQ-016 SHALL increment the pending counter by 1 on an accepted opcode 0x1F; other accepted opcodes SHALL be consumed with no effect.
REQ-017 SHALL implement FSM states IDLE, WAIT_IDLE, FIRE.
REQ-018 SHALL go IDLE -> WAIT_IDLE on the cycle after the pending counter becomes nonzero.
REQ-019 SHALL in WAIT_IDLE run a settle counter: reset to 0 on any cycle i_drawBusy is high, increment while low; transition to FIRE when it reaches SETTLE_CYCLES.
REQ-020 SHALL in FIRE assert o_setIRQ for exactly one cycle and decrement the pending counter on that same edge.
REQ-021 SHALL leave FIRE to WAIT_IDLE (settle counter cleared) if the post-decrement count is nonzero, else to IDLE.
REQ-022 SHALL, on i_gp1Valid with opcode 0x02 (IRQ acknowledge), assert o_rstIRQ for exactly one cycle, registered, on the following cycle.
REQ-023 SHALL never assert o_setIRQ and o_rstIRQ in the same cycle: if FIRE coincides with a pending o_rstIRQ pulse, FIRE SHALL hold (no pulse, no decrement) and retry next cycle.
REQ-024 SHALL, on i_gp1Valid with opcode 0x00 (GPU reset), clear pending counter and settle counter, force FSM to IDLE, and pulse o_rstIRQ on the following cycle.
REQ-025 SHALL, on i_gp1Valid with opcode 0x01 (command buffer reset), clear pending counter and settle counter and force FSM to IDLE, without pulsing o_rstIRQ.
REQ-026 SHALL give GP1 opcode 0x00/0x01 priority over a same-cycle GP0 acceptance; the accepted 0x1F SHALL be discarded.
REQ-027 SHALL leave the pending counter unchanged when an accepted 0x1F and a FIRE decrement occur on the same edge.
REQ-028 SHALL ignore all other GP1 opcodes.
REQ-029 SHALL never wrap the pending counter (full handled by REQ-015).

Reset
REQ-030 SHALL, while i_nRst is low, immediately force: FSM IDLE, pending counter 0, settle counter 0, o_setIRQ 0, o_rstIRQ 0, o_irqBusy 0; o_gp0Ready therefore 1.
REQ-031 SHALL resume normal operation on the first rising i_clk edge after i_nRst deasserts; reset asserted mid-WAIT_IDLE SHALL drop the queued request without a pulse.

Verification
REQ-032 Single IRQ: busy low, GP0 0x1F accepted at cycle 0 -> o_pendCnt=1 at cycle 1, WAIT_IDLE at cycle 2, o_setIRQ pulse one cycle after settle count reaches 2, o_pendCnt=0 afterwards.
REQ-033 Busy gating: 0x1F accepted with i_drawBusy high for 10 cycles, low glitch of 1 cycle at cycle 5 -> no o_setIRQ until busy low 2 consecutive cycles after cycle 10.
REQ-034 Full queue: four 0x1F back-to-back with busy high -> o_pendCnt=3, o_gp0Ready low on fourth; release busy -> exactly three o_setIRQ pulses, each separated by at least SETTLE_CYCLES+1 cycles.
REQ-035 Ack collision: GP1 0x02 timed so o_rstIRQ falls on FIRE cycle -> o_rstIRQ pulse first, o_setIRQ exactly one cycle later, never both high.
REQ-036 Buffer reset: o_pendCnt=2 in WAIT_IDLE, GP1 0x01 with same-cycle GP0 0x1F -> o_pendCnt=0, IDLE, no o_setIRQ, no o_rstIRQ.
REQ-037 Async reset: i_nRst low mid-WAIT_IDLE between clock edges -> all outputs 0 and o_gp0Ready 1 without waiting for i_clk.
